traffic_light_seq: RTL and testbench
====================================

Name: traffic_light_seq

Overview:
- Timed traffic-light sequencer that produces the 2-bit color code consumed by the RGB LED decoder. It is the driving end of the color-code interface.
- Cycles through INIT(WHITE) -> GREEN -> YELLOW -> RED -> GREEN, and so on, using a clock prescaler and per-phase tick counters.
- Supports a pedestrian request that shortens GREEN, plus a run-enable and a countdown output for a display.

Parameters:
- TICK_DIV, 50_000_000, clocks per tick (tick = 1 s at 50 MHz); must be >= 2.
- INIT_T, 2, ticks spent in INIT (WHITE) after reset; must be >= 1.
- GREEN_T, 10, GREEN duration in ticks; must be >= 1.
- YELLOW_T, 3, YELLOW duration in ticks; must be >= 1.
- RED_T, 8, RED duration in ticks; must be >= 1.
- MIN_GREEN, 4, minimum GREEN ticks before a pedestrian cut is allowed; 1 <= MIN_GREEN <= GREEN_T.
- CNT_W, 8, phase counter width; must hold max(all durations).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- en_i  in  1  run enable; when low, all counting freezes.
- ped_req_i  in  1  pedestrian request, level-sampled every clock.
- color_o  out  2  color code: WHITE 2'b00, RED 2'b01, GREEN 2'b10, YELLOW 2'b11 (def.v values).
- remain_o  out  CNT_W  ticks remaining in the current phase (DUR-1-elapsed).
- phase_start_o  out  1  one-clock pulse in the first clock of each new phase.
- ped_pend_o  out  1  latched pedestrian request is pending.

Behaviour:
- Reset (rst_ni low, async):
  - state = INIT, color_o = WHITE.
  - Prescaler = 0, elapsed = 0, remain_o = INIT_T-1.
  - ped_pend_o = 0, phase_start_o = 0.
- Prescaler:
  - When en_i = 1, counts 0..TICK_DIV-1 and wraps to 0.
  - tick is asserted in the clock where prescaler == TICK_DIV-1 and en_i = 1.
- When en_i = 0: prescaler, elapsed, state and ped latch updates all hold; color_o holds; no tick occurs.
- Phase counter `elapsed`:
  - Increments on tick.
  - On the terminating tick of a phase it resets to 0 and the state advances.
  - Every transition occurs on a tick edge. The new color_o and phase_start_o = 1 appear in the clock after that edge.
- Transitions (evaluated on tick only):
  - INIT: elapsed == INIT_T-1 -> GREEN.
  - GREEN: (elapsed == GREEN_T-1) OR (ped_pend && elapsed >= MIN_GREEN-1) -> YELLOW.
  - YELLOW: elapsed == YELLOW_T-1 -> RED.
  - RED: elapsed == RED_T-1 -> GREEN. No return to INIT except via reset.
- color_o is decoded directly from the state register (no extra latency).
- remain_o = DUR(state)-1-elapsed and is registered with the state. It reads DUR-1 in the first clock of each phase.
- Pedestrian latch:
  - Set when ped_req_i = 1 and en_i = 1 in INIT, GREEN or YELLOW.
  - Ignored while in RED.
  - Cleared on the clock that enters RED. If ped_req_i is high in that same clock, clear wins.
- ped_req_i arriving on the GREEN tick where elapsed >= MIN_GREEN-1 is latched that clock. It cuts GREEN at the next tick, not the current one.
- Reset asserted mid-phase: immediate return to INIT/WHITE. After release, the full INIT_T is re-timed from prescaler = 0.
- No illegal state is reachable. A default decode branch forces state = INIT and color_o = WHITE.

Test Plan:
- Use TICK_DIV=4, INIT_T=2, GREEN_T=5, YELLOW_T=2, RED_T=3, MIN_GREEN=2, en_i=1.
- Nominal sequence: release reset -> WHITE for 8 clocks, GREEN 20, YELLOW 8, RED 12, GREEN again. Period 40 clocks. phase_start_o pulses exactly once per phase; remain_o counts 4,3,2,1,0 through GREEN.
- Pedestrian cut: pulse ped_req_i for 1 clock at GREEN entry -> ped_pend_o = 1, GREEN lasts 8 clocks (2 ticks), then YELLOW. ped_pend_o returns to 0 on RED entry.
- Pedestrian in RED: hold ped_req_i = 1 throughout RED only -> ped_pend_o stays 0 and the next GREEN lasts the full 20 clocks.
- Enable freeze: drop en_i for 13 clocks during YELLOW -> color_o, remain_o and ped_pend_o hold. YELLOW total length becomes 8+13 = 21 clocks; the remaining timing is unchanged.
- Async reset mid-RED: assert rst_ni low between clock edges -> color_o = WHITE and remain_o = 1 immediately, with no clock needed. After release, WHITE lasts 8 clocks.
- Simultaneous events: ped_req_i high in the clock of the YELLOW->RED transition -> ped_pend_o = 0 in RED (clear wins).

Source files
------------

// File: rtl/traffic_light_seq.sv
// Purpose : timed traffic-light sequencer, INIT(WHITE) -> GREEN -> YELLOW -> RED -> GREEN ...
// Latency : new color/remain/phase_start appear one clock after the terminating tick edge
// Backpr. : none; en_i low freezes prescaler, phase counter, state and pedestrian latch
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   en_i          run enable, freezes all counting when low
//   ped_req_i     pedestrian request, level-sampled every clock
//   color_o       WHITE 2'b00, RED 2'b01, GREEN 2'b10, YELLOW 2'b11
//   remain_o      ticks remaining in the current phase
//   phase_start_o one-clock pulse in the first clock of a new phase
//   ped_pend_o    latched pedestrian request pending
module traffic_light_seq #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int INIT_T    = 2,
  parameter int GREEN_T   = 10,
  parameter int YELLOW_T  = 3,
  parameter int RED_T     = 8,
  parameter int MIN_GREEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             ped_req_i,
  output logic [1:0]       color_o,
  output logic [CNT_W-1:0] remain_o,
  output logic             phase_start_o,
  output logic             ped_pend_o
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [1:0] C_WHITE  = 2'b00;
  localparam logic [1:0] C_RED    = 2'b01;
  localparam logic [1:0] C_GREEN  = 2'b10;
  localparam logic [1:0] C_YELLOW = 2'b11;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_RED    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             ped_pend_q, ped_pend_d;
  logic             phase_start_q, phase_start_d;
  logic             tick;
  logic             advance;

  // Phase duration minus one, used both for the terminating compare and remain_o.
  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    case (s)
      S_INIT:   dur_m1 = CNT_W'(INIT_T - 1);
      S_GREEN:  dur_m1 = CNT_W'(GREEN_T - 1);
      S_YELLOW: dur_m1 = CNT_W'(YELLOW_T - 1);
      S_RED:    dur_m1 = CNT_W'(RED_T - 1);
      default:  dur_m1 = CNT_W'(INIT_T - 1);
    endcase
  endfunction

  assign tick = en_i && (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_INIT;
      presc_q       <= '0;
      elapsed_q     <= '0;
      remain_q      <= CNT_W'(INIT_T - 1);
      ped_pend_q    <= 1'b0;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      elapsed_q     <= elapsed_d;
      remain_q      <= remain_d;
      ped_pend_q    <= ped_pend_d;
      phase_start_q <= phase_start_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    presc_d   = presc_q;
    advance   = 1'b0;

    if (en_i) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (tick) begin
      case (state_q)
        S_INIT: begin
          if (elapsed_q == dur_m1(S_INIT)) begin
            state_d = S_GREEN;
            advance = 1'b1;
          end
        end
        S_GREEN: begin
          // Pedestrian cut uses the registered latch, so a request seen on
          // this tick only shortens GREEN from the next tick on.
          if ((elapsed_q == dur_m1(S_GREEN)) ||
              (ped_pend_q && (elapsed_q >= CNT_W'(MIN_GREEN - 1)))) begin
            state_d = S_YELLOW;
            advance = 1'b1;
          end
        end
        S_YELLOW: begin
          if (elapsed_q == dur_m1(S_YELLOW)) begin
            state_d = S_RED;
            advance = 1'b1;
          end
        end
        S_RED: begin
          if (elapsed_q == dur_m1(S_RED)) begin
            state_d = S_GREEN;
            advance = 1'b1;
          end
        end
        default: begin
          state_d = S_INIT;
          advance = 1'b1;
        end
      endcase
      elapsed_d = advance ? '0 : elapsed_q + CNT_W'(1);
    end

    remain_d      = dur_m1(state_d) - elapsed_d;
    phase_start_d = advance;

    // Clearing on RED entry takes priority over a same-clock request.
    ped_pend_d = ped_pend_q;
    if (en_i) begin
      if (advance && (state_d == S_RED)) begin
        ped_pend_d = 1'b0;
      end else if (ped_req_i && (state_q != S_RED)) begin
        ped_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    color_o = C_WHITE;
    case (state_q)
      S_INIT:   color_o = C_WHITE;
      S_GREEN:  color_o = C_GREEN;
      S_YELLOW: color_o = C_YELLOW;
      S_RED:    color_o = C_RED;
      default:  color_o = C_WHITE;
    endcase
  end

  assign remain_o      = remain_q;
  assign phase_start_o = phase_start_q;
  assign ped_pend_o    = ped_pend_q;

endmodule

// File: tb/tb_traffic_light_seq.sv
// Purpose : self-checking bench for traffic_light_seq with a small, fast parameter set
// Latency : expected per-clock outputs queued at stimulus time, compared on the falling edge
// Backpr. : none
module tb_traffic_light_seq;

  localparam int TD    = 4;
  localparam int INI   = 2;
  localparam int GRN   = 5;
  localparam int YEL   = 2;
  localparam int RD    = 3;
  localparam int MING  = 2;
  localparam int CNT_W = 8;

  localparam logic [1:0] WHITE  = 2'b00;
  localparam logic [1:0] RED    = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] YELLOW = 2'b11;

  typedef struct packed {
    logic [1:0]       c;
    logic [CNT_W-1:0] rem;
    logic             ps;
    logic             pp;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             en_i;
  logic             ped_req_i;
  logic [1:0]       color_o;
  logic [CNT_W-1:0] remain_o;
  logic             phase_start_o;
  logic             ped_pend_o;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  traffic_light_seq #(
    .TICK_DIV (TD),
    .INIT_T   (INI),
    .GREEN_T  (GRN),
    .YELLOW_T (YEL),
    .RED_T    (RD),
    .MIN_GREEN(MING),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .ped_req_i    (ped_req_i),
    .color_o      (color_o),
    .remain_o     (remain_o),
    .phase_start_o(phase_start_o),
    .ped_pend_o   (ped_pend_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: one expected record per clock, popped mid-cycle.
  always @(negedge clk_i) begin
    exp_t e;
    exp_t act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = '{c: color_o, rem: remain_o, ps: phase_start_o, pp: ped_pend_o};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL cycle_out t=%0t: got color=%b remain=%0d ps=%b pend=%b, want color=%b remain=%0d ps=%b pend=%b",
                 $time, act.c, act.rem, act.ps, act.pp, e.c, e.rem, e.ps, e.pp);
      end
    end
  end

  // Advance one clock, drive inputs for it, queue the outputs expected in it.
  task automatic cyc(input logic [1:0] c, input int rem, input bit ps, input bit pp,
                     input bit en, input bit ped);
    exp_t e;
    @(posedge clk_i);
    #1;
    en_i      = en;
    ped_req_i = ped;
    e.c   = c;
    e.rem = CNT_W'(rem);
    e.ps  = ps;
    e.pp  = pp;
    q.push_back(e);
  endtask

  // Clocks k0..k1-1 of a phase with duration dur ticks, en held high.
  task automatic phase(input logic [1:0] c, input int dur, input int k0, input int k1,
                       input bit ps0, input bit pp0, input bit pp1,
                       input bit ped0, input bit ped1);
    for (int k = k0; k < k1; k++) begin
      cyc(c, dur - 1 - k / TD, (k == 0) && ps0, (k == 0) ? pp0 : pp1, 1'b1,
          (k == 0) ? ped0 : ped1);
    end
  endtask

  // Release reset mid-cycle; that cycle is the first WHITE clock (no phase_start).
  task automatic release_reset();
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_ni    = 1'b1;
    en_i      = 1'b1;
    ped_req_i = 1'b0;
    e = '{c: WHITE, rem: CNT_W'(INI - 1), ps: 1'b0, pp: 1'b0};
    q.push_back(e);
    phase(WHITE, INI, 1, INI * TD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_ni    = 1'b0;
    en_i      = 1'b1;
    ped_req_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if ({color_o, remain_o, phase_start_o, ped_pend_o} !== {WHITE, CNT_W'(INI - 1), 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got color=%b remain=%0d ps=%b pend=%b, want 00/%0d/0/0",
               color_o, remain_o, phase_start_o, ped_pend_o, INI - 1);
    end
    release_reset();
  endtask

  task automatic test_nominal();
    phase(GREEN,  GRN, 0, GRN * TD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(YELLOW, YEL, 0, YEL * TD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    phase(RED,    RD,  0, RD * TD,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One-clock request at GREEN entry: GREEN cut to MIN_GREEN ticks.
  task automatic test_ped_cut();
    phase(GREEN,  GRN, 0, MING * TD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    phase(YELLOW, YEL, 0, YEL * TD,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Request held for all of RED only: ignored, next GREEN runs full length.
  task automatic test_ped_in_red();
    phase(RED,   RD,  0, RD * TD,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    phase(GREEN, GRN, 0, GRN * TD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Freeze 13 clocks mid-YELLOW with a request pending on the input, then a
  // request on the YELLOW->RED edge which must lose to the RED-entry clear.
  task automatic test_freeze_and_simul();
    cyc(YELLOW, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(YELLOW, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (13) cyc(YELLOW, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    phase(YELLOW, YEL, 2, YEL * TD - 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(YELLOW, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    phase(RED, RD, 0, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    #6;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({color_o, remain_o, phase_start_o, ped_pend_o} !== {WHITE, CNT_W'(INI - 1), 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got color=%b remain=%0d ps=%b pend=%b, want 00/%0d/0/0",
               color_o, remain_o, phase_start_o, ped_pend_o, INI - 1);
    end
    release_reset();
    phase(GREEN, GRN, 0, TD + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ped_cut();
    test_ped_in_red();
    test_freeze_and_simul();
    test_async_reset();
    @(negedge clk_i);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected records left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
